mem_access_unit: RTL and testbench

Multi-cycle load/store initiator in the MEM stage of the pipelined core. It accepts one load or store request at a time from the pipeline and drives the chip-select/write-enable data memory port (word-wide, little-endian, byte-addressed). Sub-word stores are built as read-modify-write because the memory only writes full words. The unit holds the pipeline with `stall` until the access completes. It returns extended load data or an error flag.

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store initiator for a word-wide, byte-addressed data memory.
// Optional range checking is enabled by defining MEM_ACCESS_RANGE_CHECK_EN.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        sgn_q, sgn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  nbytes;
  logic [32:0] last_byte;
  logic        misaligned, past_end, acc_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext, merged;

  always_comb begin
    nbytes     = req_size[1] ? 3'd4 : (req_size[0] ? 3'd2 : 3'd1);
    last_byte  = {1'b0, req_addr} + {30'b0, nbytes} - 33'd1;
    past_end   = last_byte >= 33'(MEM_BYTES);
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 (req_size[1] && (req_addr[1:0] != 2'b00));
    acc_err    = misaligned || (RANGE_CHECK && past_end);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          sgn_d   = req_signed;
          wdata_d = req_wdata;
          err_d   = acc_err;
          // Word stores skip the read; sub-word stores need the old word first.
          if (acc_err)                  state_d = S_RESP;
          else if (req_we && req_size[1]) state_d = S_WRITE;
          else                          state_d = S_READ;
        end
      end
      S_READ: begin
        rdata_d = mem_rdata;
        state_d = we_q ? S_WRITE : S_RESP;
      end
      S_WRITE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ld_byte = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_ext = rdata_q;
    endcase
    merged = rdata_q;
    if (size_q == 2'b00)      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (size_q == 2'b01) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    stall      = (state_q == S_READ) || (state_q == S_WRITE) ||
                 ((state_q == S_IDLE) && req_valid && !rst);
    resp_valid = (state_q == S_RESP);
    resp_err   = (state_q == S_RESP) && err_q;
    resp_rdata = ((state_q == S_RESP) && !we_q && !err_q) ? ld_ext : '0;
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == S_READ) begin
      mem_ce   = 1'b1;
      mem_addr = {addr_q[31:2], 2'b00};
    end else if (state_q == S_WRITE) begin
      mem_ce    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_wdata = size_q[1] ? wdata_q : merged;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit with a 1 KiB word memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        ce;
    logic [31:0] maddr;
    logic        wr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_ce && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] x_rdata, input logic x_err, input int x_lat,
                         input logic x_ce, input logic [31:0] x_maddr,
                         input logic x_wr, input logic [31:0] x_wdata);
    exp_t e;
    logic ce_seen, wr_seen, got;
    logic [31:0] first_addr, wr_data;
    int lat;
    e.tag = tag; e.rdata = x_rdata; e.err = x_err; e.lat = x_lat; e.ce = x_ce;
    e.maddr = x_maddr; e.wr = x_wr; e.wdata = x_wdata;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    ce_seen = 1'b0; wr_seen = 1'b0; got = 1'b0;
    first_addr = '0; wr_data = '0; lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_ce && !ce_seen) begin
        ce_seen = 1'b1;
        first_addr = mem_addr;
      end
      if (mem_ce && mem_we) begin
        wr_seen = 1'b1;
        wr_data = mem_wdata;
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
        check({tag, ".stall_at_resp"}, {31'b0, stall}, 32'd0);
        check({tag, ".rdata"}, resp_rdata, sb[0].rdata);
        check({tag, ".err"}, {31'b0, resp_err}, {31'b0, sb[0].err});
        break;
      end
    end
    e = sb.pop_front();
    check({tag, ".resp_seen"}, {31'b0, got}, 32'd1);
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".mem_ce"}, {31'b0, ce_seen}, {31'b0, e.ce});
    if (e.ce) check({tag, ".mem_addr"}, first_addr, e.maddr);
    check({tag, ".mem_write"}, {31'b0, wr_seen}, {31'b0, e.wr});
    if (e.wr) check({tag, ".mem_wdata"}, wr_data, e.wdata);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0C; req_wdata = '0;

    // reset with a request pending
    @(negedge clk);
    req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset.mem_ce", {31'b0, mem_ce}, 32'd0);
      check("reset.resp_valid", {31'b0, resp_valid}, 32'd0);
      check("reset.stall", {31'b0, stall}, 32'd0);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("reset.req_ready", {31'b0, req_ready}, 32'd1);
    check("reset.stall_idle", {31'b0, stall}, 32'd0);

    run_req("st_w_0c", 1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF,
            32'h0, 1'b0, 2, 1'b1, 32'h0C, 1'b1, 32'hDEADBEEF);
    check("mem0c_after_sw", mem[3], 32'hDEADBEEF);
    run_req("st_b_0d", 1'b1, 2'b00, 1'b0, 32'h0D, 32'h00000055,
            32'h0, 1'b0, 3, 1'b1, 32'h0C, 1'b1, 32'hDEAD55EF);
    check("mem0c_after_sb", mem[3], 32'hDEAD55EF);
    run_req("st_h_0e", 1'b1, 2'b01, 1'b0, 32'h0E, 32'hFFFF1234,
            32'h0, 1'b0, 3, 1'b1, 32'h0C, 1'b1, 32'h123455EF);
    run_req("st_w_00", 1'b1, 2'b10, 1'b0, 32'h00, 32'hA5A5A5A5,
            32'h0, 1'b0, 2, 1'b1, 32'h00, 1'b1, 32'hA5A5A5A5);
    run_req("st_w_3fc", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D,
            32'h0, 1'b0, 2, 1'b1, 32'h3FC, 1'b1, 32'hCAFEF00D);
    run_req("st_w_0c_b", 1'b1, 2'b10, 1'b0, 32'h0C, 32'h80FF7F01,
            32'h0, 1'b0, 2, 1'b1, 32'h0C, 1'b1, 32'h80FF7F01);

    run_req("ld_sb_0f", 1'b0, 2'b00, 1'b1, 32'h0F, 32'h0,
            32'hFFFFFF80, 1'b0, 2, 1'b1, 32'h0C, 1'b0, 32'h0);
    run_req("ld_ub_0f", 1'b0, 2'b00, 1'b0, 32'h0F, 32'h0,
            32'h00000080, 1'b0, 2, 1'b1, 32'h0C, 1'b0, 32'h0);
    run_req("ld_sh_0e", 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0,
            32'hFFFF80FF, 1'b0, 2, 1'b1, 32'h0C, 1'b0, 32'h0);
    run_req("ld_sb_0c", 1'b0, 2'b00, 1'b1, 32'h0C, 32'h0,
            32'h00000001, 1'b0, 2, 1'b1, 32'h0C, 1'b0, 32'h0);
    run_req("ld_uh_0c", 1'b0, 2'b01, 1'b0, 32'h0C, 32'h0,
            32'h00007F01, 1'b0, 2, 1'b1, 32'h0C, 1'b0, 32'h0);
    run_req("ld_sz3_0c", 1'b0, 2'b11, 1'b1, 32'h0C, 32'h0,
            32'h80FF7F01, 1'b0, 2, 1'b1, 32'h0C, 1'b0, 32'h0);
    run_req("ld_sb_3ff", 1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0,
            32'hFFFFFFCA, 1'b0, 2, 1'b1, 32'h3FC, 1'b0, 32'h0);

    run_req("ld_w_mis02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0,
            32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0);
    run_req("st_h_mis01", 1'b1, 2'b01, 1'b0, 32'h01, 32'h1234,
            32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    run_req("ld_w_400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,
            32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0);
    run_req("ld_h_3ff_edge", 1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0,
            32'h0000CAFE, 1'b0, 2, 1'b1, 32'h3FC, 1'b0, 32'h0);
`else
    run_req("ld_w_400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,
            32'hA5A5A5A5, 1'b0, 2, 1'b1, 32'h400, 1'b0, 32'h0);
    run_req("ld_h_3ff_edge", 1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0,
            32'h0000CAFE, 1'b0, 2, 1'b1, 32'h3FC, 1'b0, 32'h0);
`endif

    @(negedge clk);
    check("final.req_ready", {31'b0, req_ready}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
